// File: rtl/handshake_tx.sv
// handshake_tx: four-phase req/ack sender with a resynchronized ack return.
// Optional REQ-state timeout is compiled in with HANDSHAKE_TX_TIMEOUT_EN.
module handshake_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  ack_async,
   output logic                  ready,
   output logic                  req,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  done,
   output logic                  timeout
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("handshake_tx: illegal parameter value");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [SYNC_STAGES-1:0]  ack_sync;
   logic                    ack_s;
   logic                    req_d;
   logic [DATA_WIDTH-1:0]   data_d;
   logic                    done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign ready = (state_q == IDLE) && !ack_s;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
   localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        abort_q;
   logic        abort_d;
   logic        timeout_q;
   logic        timeout_d;
   logic        cnt_hit;

   // cnt_q counts completed REQ cycles; this edge would make it one more
   assign cnt_hit = ({1'b0, cnt_q} + 17'd1) >= TO_LIM;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req;
      data_d  = data_out;
      done_d  = 1'b0;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      cnt_d     = cnt_q;
      abort_d   = abort_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (send && ready) begin
               state_d = REQ;
               req_d   = 1'b1;
               data_d  = tx_data;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
               cnt_d   = '0;
               abort_d = 1'b0;
`endif
            end
         end
         REQ: begin
            if (ack_s) begin
               state_d = RELEASE;
               req_d   = 1'b0;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
            end else if (cnt_hit) begin
               state_d   = RELEASE;
               req_d     = 1'b0;
               timeout_d = 1'b1;
               abort_d   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         RELEASE: begin
            if (!ack_s) begin
               state_d = IDLE;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
               done_d  = !abort_q;
               abort_d = 1'b0;
`else
               done_d  = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         req      <= 1'b0;
         data_out <= '0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         req      <= req_d;
         data_out <= data_d;
         done     <= done_d;
      end
   end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         abort_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         abort_q   <= abort_d;
         timeout_q <= timeout_d;
      end
   end
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx: vector table, corner sequences and a randomized
// responder checked against a cycle-level behavioural model.
module tb_handshake_tx;

   localparam int DW = 8;
   localparam int S  = 2;
   localparam int TO = 4;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          tb_clk = 1'b0;
   logic          rst = 1'b0;
   logic          send = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          ack_async = 1'b0;
   logic          ready;
   logic          req;
   logic [DW-1:0] data_out;
   logic          done;
   logic          timeout;

   int checks   = 0;
   int failures = 0;

   always #5 tb_clk = ~tb_clk;

   handshake_tx #(
      .DATA_WIDTH    (DW),
      .SYNC_STAGES   (S),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (tb_clk),
      .rst      (rst),
      .send     (send),
      .tx_data  (tx_data),
      .ack_async(ack_async),
      .ready    (ready),
      .req      (req),
      .data_out (data_out),
      .done     (done),
      .timeout  (timeout)
   );

   typedef struct {
      logic          send;
      logic [DW-1:0] d;
      logic          ack;
      logic          e_req;
      logic          e_ready;
      logic          e_done;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t tbl[13];

   // behavioural model: 0 waiting for work, 1 request out, 2 awaiting release
   int            m_phase;
   int            m_wait;
   bit            m_abort;
   logic          m_req;
   logic [DW-1:0] m_data;
   logic          m_done;
   logic          m_to;
   logic          hist[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_wait  = 0;
      m_abort = 1'b0;
      m_req   = 1'b0;
      m_data  = '0;
      m_done  = 1'b0;
      m_to    = 1'b0;
      hist    = {};
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
   endtask

   task automatic model_edge(input logic s, input logic [DW-1:0] d,
                             input logic a);
      logic seen;
      seen   = hist[0];
      m_done = 1'b0;
      m_to   = 1'b0;
      if (m_phase == 0) begin
         if (s && !seen) begin
            m_phase = 1;
            m_req   = 1'b1;
            m_data  = d;
            m_wait  = 0;
            m_abort = 1'b0;
         end
      end else if (m_phase == 1) begin
         m_wait++;
         if (seen) begin
            m_req   = 1'b0;
            m_phase = 2;
         end else if (TO_EN && m_wait >= TO) begin
            m_req   = 1'b0;
            m_to    = 1'b1;
            m_abort = 1'b1;
            m_phase = 2;
         end
      end else begin
         if (!seen) begin
            m_phase = 0;
            m_done  = !m_abort;
         end
      end
      hist.push_back(a);
      void'(hist.pop_front());
   endtask

   initial begin
      logic          prev;
      logic [DW-1:0] hv;
      int            edges;
      int            dones;
      bit            bad_x;
      bit            bad_data;
      bit            order;

      // reset
      #2 rst = 1'b1;
      #1;
      chk("rst_req", req, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      @(posedge tb_clk);
      #1 rst = 1'b0;

      // normal handshake, busy drop, stale ack
      tbl[0]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
      tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[10] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
      for (int i = 0; i < 13; i++) begin
         send      = tbl[i].send;
         tx_data   = tbl[i].d;
         ack_async = tbl[i].ack;
         step();
         chk($sformatf("vec%0d_req", i), req, tbl[i].e_req);
         chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_ready);
         chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("vec%0d_data", i), data_out, tbl[i].e_data);
         chk($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      end
      send = 1'b0;

      // unacknowledged request
      send    = 1'b1;
      tx_data = 8'h77;
      step();
      send = 1'b0;
      chk("to_req_entry", req, 1'b1);
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      for (int i = 1; i < TO; i++) begin
         step();
         chk($sformatf("to_req_hold%0d", i), req, 1'b1);
         chk($sformatf("to_pulse_early%0d", i), timeout, 1'b0);
      end
      step();
      chk("to_req_fall", req, 1'b0);
      chk("to_pulse", timeout, 1'b1);
      chk("to_no_done", done, 1'b0);
      step();
      chk("to_pulse_end", timeout, 1'b0);
      chk("to_no_done2", done, 1'b0);
      chk("to_ready", ready, 1'b1);
`else
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("wait_req_hold%0d", i), req, 1'b1);
         chk($sformatf("wait_no_timeout%0d", i), timeout, 1'b0);
      end
      ack_async = 1'b1;
      for (int i = 0; i < 10 && req; i++) step();
      chk("wait_req_release", req, 1'b0);
      ack_async = 1'b0;
      dones = 0;
      for (int i = 0; i < 10 && !ready; i++) begin
         step();
         if (done) dones++;
      end
      chk("wait_done_count", dones, 1);
      chk("wait_ready", ready, 1'b1);
`endif

      // asynchronous reset in the middle of REQ
      send    = 1'b1;
      tx_data = 8'hA5;
      step();
      send = 1'b0;
      step();
      chk("mid_req_pre", req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_req", req, 1'b0);
      chk("mid_rst_data", data_out, 8'h00);
      chk("mid_rst_ready", ready, 1'b1);
      chk("mid_rst_done", done, 1'b0);
      @(posedge tb_clk);
      #1 rst = 1'b0;

      // ack edges placed just before or just after clock edges
      for (int h = 0; h < 4; h++) begin
         hv       = 8'hC0 + 8'(h);
         edges    = 0;
         dones    = 0;
         bad_x    = 1'b0;
         bad_data = 1'b0;
         order    = 1'b1;
         prev     = req;
         send     = 1'b1;
         tx_data  = hv;
         for (int c = 0; c < 40; c++) begin
            step();
            send = 1'b0;
            if ($isunknown({req, ready, done, data_out})) bad_x = 1'b1;
            if (req !== prev) edges++;
            prev = req;
            if (done) begin
               dones++;
               if (edges != 2) order = 1'b0;
            end
            if (edges > 0 && data_out !== hv) bad_data = 1'b1;
            if (dones > 0 && !done) break;
            if (ack_async !== req) begin
               if (h % 2 == 1) #8;
               ack_async = req;
            end
         end
         chk($sformatf("async%0d_req_edges", h), edges, 2);
         chk($sformatf("async%0d_done_count", h), dones, 1);
         chk($sformatf("async%0d_no_x", h), bad_x, 1'b0);
         chk($sformatf("async%0d_data_stable", h), bad_data, 1'b0);
         chk($sformatf("async%0d_order", h), order, 1'b1);
      end

      // randomized responder against the model
      ack_async = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge tb_clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         send    = ($urandom_range(0, 3) == 0);
         tx_data = DW'($urandom);
         if (req && !ack_async) begin
            if ($urandom_range(0, 2) == 0) ack_async = 1'b1;
         end else if (req && ack_async) begin
            if ($urandom_range(0, 9) == 0) ack_async = 1'b0;
         end else if (ack_async) begin
            if ($urandom_range(0, 1) == 0) ack_async = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            ack_async = 1'b1;
         end
         model_edge(send, tx_data, ack_async);
         step();
         chk("rnd_req", req, m_req);
         chk("rnd_ready", ready, (m_phase == 0) && !hist[0]);
         chk("rnd_done", done, m_done);
         chk("rnd_timeout", timeout, m_to);
         chk("rnd_data", data_out, m_data);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
